// File: rtl/bus_command_pkg.sv
// Shared types for the 8288-style bus command generator.
//   bus_state_t  : T-state sequence of one bus cycle
//   bus_status_t : decoded 8088 S2..S0 status
//   cmd_sel_t    : one-hot command select for the latched cycle type
package bus_command_pkg;

  localparam int unsigned STATUS_W = 3;
  localparam int unsigned WAIT_W   = 3;

  localparam logic [STATUS_W-1:0] STATUS_PASSIVE = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    T3,
    TW,
    T4
  } bus_state_t;

  typedef enum logic [STATUS_W-1:0] {
    INTA    = 3'b000,
    IORD    = 3'b001,
    IOWR    = 3'b010,
    HALT    = 3'b011,
    CODE    = 3'b100,
    MEMRD   = 3'b101,
    MEMWR   = 3'b110,
    PASSIVE = 3'b111
  } bus_status_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic io_read;
    logic io_write;
    logic inta;
  } cmd_sel_t;

endpackage

// File: rtl/bus_command_generator_if.sv
// CPU-status / chipset-command bundle of the bus command generator.
//   master : controller side (samples status/ready/AEN, drives ALE, DEN, DT/R#, commands)
//   slave  : CPU/chipset side
interface bus_command_generator_if;

  logic [2:0] processor_status;
  logic       processor_ready;
  logic       bus_disable;
  logic       address_latch_enable;
  logic       data_enable;
  logic       processor_transmit_or_receive_n;
  logic       memory_read_n;
  logic       memory_write_n;
  logic       io_read_n;
  logic       io_write_n;
  logic       interrupt_acknowledge_n;
  logic       halt;
  logic       bus_cycle_active;

  modport master (
    input  processor_status, processor_ready, bus_disable,
    output address_latch_enable, data_enable, processor_transmit_or_receive_n,
           memory_read_n, memory_write_n, io_read_n, io_write_n,
           interrupt_acknowledge_n, halt, bus_cycle_active
  );

  modport slave (
    output processor_status, processor_ready, bus_disable,
    input  address_latch_enable, data_enable, processor_transmit_or_receive_n,
           memory_read_n, memory_write_n, io_read_n, io_write_n,
           interrupt_acknowledge_n, halt, bus_cycle_active
  );

endinterface

// File: rtl/bus_status_decoder.sv
// Combinational decode of a latched bus status into a one-hot command select.
//   status   in  : latched 8088 status
//   cmd_sel  out : which command the cycle drives
//   is_read  out : read class (MRDC, IORC, INTA)
//   is_write out : write class (MWTC, IOWC)
//   is_io    out : I/O cycle (selects the I/O wait-state count)
//   is_halt  out : halt status, flagged but never commanded
module bus_status_decoder
  import bus_command_pkg::*;
(
  input  bus_status_t status,
  output cmd_sel_t    cmd_sel,
  output logic        is_read,
  output logic        is_write,
  output logic        is_io,
  output logic        is_halt
);

  always_comb begin
    cmd_sel = '0;
    is_io   = 1'b0;
    is_halt = 1'b0;
    case (status)
      INTA:        cmd_sel.inta = 1'b1;
      IORD:        begin cmd_sel.io_read  = 1'b1; is_io = 1'b1; end
      IOWR:        begin cmd_sel.io_write = 1'b1; is_io = 1'b1; end
      HALT:        is_halt = 1'b1;
      CODE, MEMRD: cmd_sel.mem_read  = 1'b1;
      MEMWR:       cmd_sel.mem_write = 1'b1;
      default:     ;
    endcase
  end

  assign is_read  = cmd_sel.mem_read | cmd_sel.io_read | cmd_sel.inta;
  assign is_write = cmd_sel.mem_write | cmd_sel.io_write;

endmodule

// File: rtl/bus_command_generator.sv
// 8288-equivalent bus controller: sequences T1/T2/T3/Tw/T4 for each
// non-passive 8088 status and drives ALE, DEN, DT/R# and the active-low commands.
//   clock, reset : CPU clock, asynchronous active-high reset
//   bus          : bus_command_generator_if.master (status/ready/AEN in, commands out)
// Build option: define ADVANCED_WRITE_CMD_EN to assert MWTC/IOWC from T2
// (advanced write timing) instead of T3.
module bus_command_generator
  import bus_command_pkg::*;
#(
  parameter int unsigned MEM_WAIT_STATES = 0,
  parameter int unsigned IO_WAIT_STATES  = 1
) (
  input  logic clock,
  input  logic reset,
  bus_command_generator_if.master bus
);

  if (MEM_WAIT_STATES > 7 || IO_WAIT_STATES > 7) begin : g_wait_range
    $error("wait-state parameters must fit the 3-bit wait counter");
  end

  bus_state_t        state_q, state_d;
  bus_status_t       type_q, type_d;
  logic              armed_q, armed_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  cmd_sel_t sel;
  logic     dec_read, dec_write, dec_io, dec_halt;

  logic cmd_window, write_window;
  logic ale_d, halt_d, den_d, dtr_d, active_d;
  logic mrd_d, mwr_d, iord_d, iowr_d, inta_d;
  logic ale_q, halt_q, den_q, dtr_q, active_q;
  logic mrd_q, mwr_q, iord_q, iowr_q, inta_q;

  // Decode the type the next state will run under, so registered outputs line up with it.
  bus_status_decoder u_decoder (
    .status   (type_d),
    .cmd_sel  (sel),
    .is_read  (dec_read),
    .is_write (dec_write),
    .is_io    (dec_io),
    .is_halt  (dec_halt)
  );

  // Next-state, wait counter, arming and next output values.
  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    armed_d      = armed_q;
    wait_d       = wait_q;
    cmd_window   = 1'b0;
    write_window = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.processor_status == STATUS_PASSIVE) begin
          armed_d = 1'b1;
        end else if (armed_q && !bus.bus_disable) begin
          state_d = T1;
          type_d  = bus_status_t'(bus.processor_status);
          armed_d = 1'b0;
        end
      end
      T1: begin
        if (dec_halt) begin
          state_d = IDLE;
        end else begin
          state_d = T2;
          wait_d  = dec_io ? WAIT_W'(IO_WAIT_STATES) : WAIT_W'(MEM_WAIT_STATES);
        end
      end
      T2: state_d = T3;
      // Forced waits are consumed first; ready only matters once the counter is empty.
      T3, TW: begin
        if (wait_q != '0) begin
          wait_d  = wait_q - WAIT_W'(1);
          state_d = TW;
        end else if (bus.processor_ready) begin
          state_d = T4;
        end else begin
          state_d = TW;
        end
      end
      T4:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cmd_window = (state_d == T2) || (state_d == T3) || (state_d == TW);
`ifdef ADVANCED_WRITE_CMD_EN
    write_window = cmd_window;
`else
    write_window = (state_d == T3) || (state_d == TW);
`endif

    ale_d    = (state_d == T1);
    halt_d   = (state_d == T1) && dec_halt;
    active_d = (state_d != IDLE);
    dtr_d    = active_d && dec_write;
    den_d    = cmd_window && (dec_read || dec_write);
    mrd_d    = cmd_window && sel.mem_read;
    iord_d   = cmd_window && sel.io_read;
    inta_d   = cmd_window && sel.inta;
    mwr_d    = write_window && sel.mem_write;
    iowr_d   = write_window && sel.io_write;
  end

  // State and output registers; outputs change on the edge entering each state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      type_q   <= PASSIVE;
      armed_q  <= 1'b1;
      wait_q   <= '0;
      ale_q    <= 1'b0;
      halt_q   <= 1'b0;
      den_q    <= 1'b0;
      dtr_q    <= 1'b0;
      active_q <= 1'b0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      iord_q   <= 1'b0;
      iowr_q   <= 1'b0;
      inta_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      armed_q  <= armed_d;
      wait_q   <= wait_d;
      ale_q    <= ale_d;
      halt_q   <= halt_d;
      den_q    <= den_d;
      dtr_q    <= dtr_d;
      active_q <= active_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      iord_q   <= iord_d;
      iowr_q   <= iowr_d;
      inta_q   <= inta_d;
    end
  end

  // AEN gates commands and DEN without a clock so DMA takes the bus at once;
  // the sequencer keeps running to preserve CPU timing.
  assign bus.address_latch_enable            = ale_q;
  assign bus.halt                            = halt_q;
  assign bus.bus_cycle_active                = active_q;
  assign bus.processor_transmit_or_receive_n = dtr_q;
  assign bus.data_enable                     = den_q  & ~bus.bus_disable;
  assign bus.memory_read_n                   = ~(mrd_q  & ~bus.bus_disable);
  assign bus.memory_write_n                  = ~(mwr_q  & ~bus.bus_disable);
  assign bus.io_read_n                       = ~(iord_q & ~bus.bus_disable);
  assign bus.io_write_n                      = ~(iowr_q & ~bus.bus_disable);
  assign bus.interrupt_acknowledge_n         = ~(inta_q & ~bus.bus_disable);

endmodule
